buffered_input_port: RTL and testbench

//  Parametrised buffered router input port with X-Y routing. Accepts flits over a valid/ready handshake into a DEPTH-entry FIFO.
//  The flit at the FIFO head is routed, tagged with a 3-bit output-port code and held in a one-entry output register.

---
 rtl/buffered_input_port.sv | 133 +++++++++++++
 tb/tb_buffered_input_port.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/buffered_input_port.sv
// Buffered mesh-router input port: DEPTH-entry flit FIFO, X-then-Y route computation
// on the FIFO head, and a one-entry output register that drives one of five port valids.
module buffered_input_port #(
   parameter int FLIT_W = 12,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        routerAddress,
   input  logic [FLIT_W-1:0]        inFlit,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic                     portBlock,
   output logic [FLIT_W+2:0]        outFlit,
   output logic [4:0]               outValid,
   input  logic [4:0]               outReady,
   output logic [$clog2(DEPTH):0]   fifoCount,
   output logic [CNT_W-1:0]         fwdCount
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = FLIT_W + 3;
   localparam int HW = ADDR_W / 2;

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [OW-1:0]     out_q, out_d;
   logic              reg_valid_q, reg_valid_d;
   logic [CNT_W-1:0]  fwd_q, fwd_d;

   logic              push, load, hold, sel_ready;
   logic [FLIT_W-1:0] head;
   logic [ADDR_W-1:0] dst;
   logic [2:0]        port_code, reg_port;

   // Route the FIFO head: resolve X first, then Y, else deliver locally.
   always_comb begin
      head = mem_q[rd_ptr_q];
      dst  = head[FLIT_W-1 -: ADDR_W];
      if (dst[ADDR_W-1 -: HW] > routerAddress[ADDR_W-1 -: HW]) begin
         port_code = 3'd2;
      end else if (dst[ADDR_W-1 -: HW] < routerAddress[ADDR_W-1 -: HW]) begin
         port_code = 3'd4;
      end else if (dst[HW-1:0] > routerAddress[HW-1:0]) begin
         port_code = 3'd1;
      end else if (dst[HW-1:0] < routerAddress[HW-1:0]) begin
         port_code = 3'd3;
      end else begin
         port_code = 3'd0;
      end
   end

   // Handshake decode; only the addressed port's ready is consulted.
   always_comb begin
      reg_port = out_q[OW-1 -: 3];
      case (reg_port)
         3'd0:    sel_ready = outReady[0];
         3'd1:    sel_ready = outReady[1];
         3'd2:    sel_ready = outReady[2];
         3'd3:    sel_ready = outReady[3];
         3'd4:    sel_ready = outReady[4];
         default: sel_ready = 1'b0;
      endcase
      inReady = (count_q != CW'(DEPTH));
      push    = inValid & inReady;
      hold    = reg_valid_q & sel_ready & ~portBlock;
      load    = ~portBlock & (count_q != '0) & (~reg_valid_q | hold);
   end

   // Next-state for pointers, occupancy, output register and handoff counter.
   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
      fwd_d       = hold ? fwd_q + CNT_W'(1) : fwd_q;
      out_d       = out_q;
      reg_valid_d = reg_valid_q;
      case ({push, load})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (load) begin
         out_d       = {port_code, head};
         reg_valid_d = 1'b1;
      end else if (hold) begin
         reg_valid_d = 1'b0;
      end else begin
         reg_valid_d = reg_valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_q       <= '0;
         reg_valid_q <= 1'b0;
         fwd_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_q       <= out_d;
         reg_valid_q <= reg_valid_d;
         fwd_q       <= fwd_d;
      end
   end

   // Flit storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= inFlit;
      end
   end

   // A stalled port shows no valid, but the register contents stay put.
   always_comb begin
      for (int p = 0; p < 5; p++) begin
         outValid[p] = reg_valid_q & (reg_port == 3'(p)) & ~portBlock;
      end
      outFlit   = out_q;
      fifoCount = count_q;
      fwdCount  = fwd_q;
   end

endmodule

// File: tb/tb_buffered_input_port.sv
// Self-checking bench for buffered_input_port: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_buffered_input_port;

   localparam int FLIT_W = 12;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] routerAddress;
   logic [FLIT_W-1:0] inFlit;
   logic              inValid;
   logic              inReady;
   logic              portBlock;
   logic [FLIT_W+2:0] outFlit;
   logic [4:0]        outValid;
   logic [4:0]        outReady;
   logic [2:0]        fifoCount;
   logic [CNT_W-1:0]  fwdCount;

   buffered_input_port #(.FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .routerAddress(routerAddress), .inFlit(inFlit),
      .inValid(inValid), .inReady(inReady), .portBlock(portBlock), .outFlit(outFlit),
      .outValid(outValid), .outReady(outReady), .fifoCount(fifoCount), .fwdCount(fwdCount)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [FLIT_W-1:0] m_fifo[$];
   logic [FLIT_W-1:0] m_order[$];
   bit                m_v;
   logic [FLIT_W+2:0] m_flit;
   int                m_fwd;

   function automatic logic [2:0] route(input logic [FLIT_W-1:0] f, input logic [ADDR_W-1:0] me);
      int dx, dy, cx, cy;
      dx = f[11:10]; dy = f[9:8]; cx = me[3:2]; cy = me[1:0];
      if (dx > cx) return 3'd2;
      if (dx < cx) return 3'd4;
      if (dy > cy) return 3'd1;
      if (dy < cy) return 3'd3;
      return 3'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, then advance the model across the edge.
   task automatic cycle();
      bit push, hand, load;
      logic [FLIT_W-1:0] f, in_s;
      logic [2:0] mp;
      #1;
      mp   = m_flit[FLIT_W+2:FLIT_W];
      chk("inReady", 32'(inReady), 32'(m_fifo.size() < DEPTH));
      chk("fifoCount", 32'(fifoCount), 32'(m_fifo.size()));
      chk("outValid", 32'(outValid), (m_v && !portBlock) ? (32'd1 << mp) : 32'd0);
      chk("outFlit", 32'(outFlit), 32'(m_flit));
      chk("fwdCount", 32'(fwdCount), 32'(m_fwd % 65536));
      push = inValid && (m_fifo.size() < DEPTH);
      hand = m_v && outReady[mp] && !portBlock;
      load = !portBlock && (m_fifo.size() > 0) && (!m_v || hand);
      if (hand && !reset) chk("order", 32'(outFlit[FLIT_W-1:0]), 32'(m_order.pop_front()));
      in_s = inFlit;
      @(posedge clk);
      if (reset) begin
         m_fifo.delete(); m_order.delete();
         m_v = 1'b0; m_flit = '0; m_fwd = 0;
      end else begin
         if (load) begin
            f = m_fifo.pop_front();
            m_flit = {route(f, routerAddress), f};
            m_v = 1'b1;
         end else if (hand) begin
            m_v = 1'b0;
         end
         if (push) begin
            m_fifo.push_back(in_s);
            m_order.push_back(in_s);
         end
         if (hand) m_fwd++;
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [FLIT_W-1:0] f);
      int guard = 0;
      inFlit = f; inValid = 1'b1;
      while (!inReady && guard < 50) begin cycle(); guard++; end
      if (guard >= 50) chk("send_timeout", 32'(guard), 32'd0);
      cycle();
      inValid = 1'b0;
   endtask

   initial begin
      logic [3:0] dests [5];
      reset = 1'b1; routerAddress = 4'b0101; inFlit = '0; inValid = 1'b0;
      portBlock = 1'b0; outReady = 5'b00000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_v = 1'b0; m_flit = '0; m_fwd = 0;
      cycle();

      // routing of single flits: East, Local, North, West, South
      dests[0] = 4'b1001; dests[1] = 4'b0101; dests[2] = 4'b0111;
      dests[3] = 4'b0001; dests[4] = 4'b0100;
      outReady = 5'b11111;
      for (int i = 0; i < 5; i++) begin
         send({dests[i], 8'(8'h10 + i)});
         repeat (2) cycle();
      end

      // backpressure: fill register plus FIFO, extra pushes stall
      outReady = 5'b00000;
      for (int i = 0; i < 5; i++) send({4'b1001, 8'(8'h20 + i)});
      inFlit = 12'h9AA; inValid = 1'b1;
      repeat (3) cycle();
      outReady = 5'b11111;
      repeat (3) cycle();
      inValid = 1'b0;
      repeat (8) cycle();

      // streaming 8 flits at full rate
      for (int i = 0; i < 8; i++) begin
         inFlit = 12'($urandom); inValid = 1'b1;
         cycle();
      end
      inValid = 1'b0;
      repeat (4) cycle();

      // portBlock with register full
      outReady = 5'b00000;
      for (int i = 0; i < 3; i++) send({4'b0111, 8'(8'h40 + i)});
      outReady = 5'b11111; portBlock = 1'b1;
      repeat (3) cycle();
      portBlock = 1'b0;
      repeat (6) cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         inFlit    = 12'($urandom);
         inValid   = 1'($urandom_range(0, 1));
         outReady  = 5'($urandom);
         portBlock = ($urandom_range(0, 7) == 0);
         cycle();
      end
      inValid = 1'b0; portBlock = 1'b0; outReady = 5'b11111;
      repeat (8) cycle();

      // reset with flits buffered
      outReady = 5'b00000;
      for (int i = 0; i < 4; i++) send({4'b1001, 8'(8'h60 + i)});
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (2) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
